// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-master arbiter for the single-port Data RAM
//
// Purpose:
//   Shares one single-port synchronous Data RAM between the pipeline data
//   port (m0) and a secondary master (m1, I-fetch refill or debug loader).
//   m0 has priority. A starvation counter forces an m1 grant after
//   STARVE_LIMIT consecutive denied cycles. Read data is routed back to the
//   owning master exactly one cycle after its grant.
//
// Ports:
//   clk                 clock, all state on rising edge
//   reset               asynchronous active-low reset
//   mX_req/addr/wen/wdata   request and payload, held until granted
//   mX_gnt              access accepted this cycle (combinational)
//   mX_rvalid/rdata     read response, one cycle after a granted read
//   ram_en/addr/wen/wdata   RAM command, zero when nothing is granted
//   ram_rdata           RAM read data, valid one cycle after a read enable
module data_ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wen,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wen,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        ram_en,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic {
    NORMAL   = 1'b0,
    FORCE_M1 = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;

  logic        gnt0, gnt1;
  logic        m1_denied;

  // Grant decode. Gated by reset so every output reads 0 while held in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      case (state_q)
        NORMAL: begin
          gnt0 = m0_req;
          gnt1 = m1_req & ~m0_req;
        end
        FORCE_M1: begin
          gnt1 = m1_req;
          gnt0 = m0_req & ~m1_req;
        end
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  assign m1_denied = m1_req & ~gnt1;

  // Next-state logic for the starvation counter, FSM and response tracker.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;

    if (!m1_req || gnt1) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    case (state_q)
      NORMAL:   if (m1_denied && (starve_cnt_q == LIMIT_M1)) state_d = FORCE_M1;
      FORCE_M1: if (gnt1 || !m1_req) state_d = NORMAL;
      default:  state_d = NORMAL;
    endcase

    // Only reads produce a response; the owner is whoever was granted.
    if ((gnt0 && (m0_wen == 4'b0000)) || (gnt1 && (m1_wen == 4'b0000))) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= NORMAL;
      starve_cnt_q <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // RAM command mux from the granted master.
  always_comb begin
    ram_addr  = 32'h0;
    ram_wen   = 4'b0000;
    ram_wdata = 32'h0;
    if (gnt0) begin
      ram_addr  = m0_addr;
      ram_wen   = m0_wen;
      ram_wdata = m0_wdata;
    end else if (gnt1) begin
      ram_addr  = m1_addr;
      ram_wen   = m1_wen;
      ram_wdata = m1_wdata;
    end
  end

  assign ram_en    = gnt0 | gnt1;
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = resp_valid_q & ~resp_id_q;
  assign m1_rvalid = resp_valid_q & resp_id_q;
  assign m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - scoreboard bench for data_ram_arbiter
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wen, m1_wen;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rdata = 32'h0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } resp_t;
  resp_t exp_q[$];
  resp_t mon_e;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] wtmp;

  data_ram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wen(ram_wen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == 4'b0000) begin
        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
      end else begin
        wtmp = mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) wtmp[8*b +: 8] = ram_wdata[8*b +: 8];
        mem[ram_addr] = wtmp;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a response is due or seen.
  always @(negedge clk) begin
    if (reset === 1'b1 || m0_rvalid || m1_rvalid) begin
      if (m0_rvalid || m1_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 32'({m0_rvalid, m1_rvalid}), 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rvalid_latency", 32'(cyc - mon_e.cyc), 32'd1);
          chk("rvalid_route", 32'({m0_rvalid, m1_rvalid}), mon_e.id ? 32'h1 : 32'h2);
          chk("rdata", mon_e.id ? m1_rdata : m0_rdata, mon_e.data);
          chk("rdata_other_zero", mon_e.id ? m0_rdata : m1_rdata, 32'h0);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        chk("rvalid_missing", 32'({m0_rvalid, m1_rvalid}), mon_e.id ? 32'h1 : 32'h2);
      end
    end
  end

  // One cycle of stimulus: drive after the edge, check grants and RAM
  // command at the negedge, and push the expected read response.
  task automatic step(input string name,
                      input logic r0, input logic [31:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                      input logic r1, input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1,
                      input logic eg0, input logic eg1, input logic [31:0] ed);
    resp_t e;
    m0_req = r0; m0_addr = a0; m0_wen = w0; m0_wdata = d0;
    m1_req = r1; m1_addr = a1; m1_wen = w1; m1_wdata = d1;
    @(negedge clk);
    chk({name, "_m0_gnt"}, 32'(m0_gnt), 32'(eg0));
    chk({name, "_m1_gnt"}, 32'(m1_gnt), 32'(eg1));
    chk({name, "_ram_en"}, 32'(ram_en), 32'(eg0 | eg1));
    chk({name, "_ram_addr"}, ram_addr, eg0 ? a0 : (eg1 ? a1 : 32'h0));
    chk({name, "_ram_wen"}, 32'(ram_wen), 32'(eg0 ? w0 : (eg1 ? w1 : 4'h0)));
    chk({name, "_ram_wdata"}, ram_wdata, eg0 ? d0 : (eg1 ? d1 : 32'h0));
    if ((eg0 && w0 == 4'h0) || (eg1 && w1 == 4'h0)) begin
      e.id = eg1; e.data = ed; e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string name);
    step(name, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h10]  = 32'hA5A5_0010;
    mem[32'h20]  = 32'h5A5A_0020;
    mem[32'h40]  = 32'h1111_2222;
    mem[32'h80]  = 32'h3333_4444;
    mem[32'h100] = 32'hDEAD_BEEF;
    mem[32'h8]   = 32'h1234_5678;

    // Reset held with both masters requesting: every output must be 0.
    reset = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h10; m0_wen = 4'h0; m0_wdata = 32'hFFFF_FFFF;
    m1_req = 1'b1; m1_addr = 32'h20; m1_wen = 4'hF; m1_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
      chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
      chk("rst_ram_en", 32'(ram_en), 32'h0);
      chk("rst_ram_bus", ram_addr | ram_wdata | 32'(ram_wen), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    step("rel0", 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b1, 1'b0, 32'hA5A5_0010);
    step("rel1", 1'b0, 32'h0,  4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 1'b1, 32'h5A5A_0020);
    idle("rel_idle");

    // m0 read at 0x100.
    step("m0rd", 1'b1, 32'h100, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle("m0rd_idle");

    // Starvation: m0 writes every cycle, m1 read held until granted.
    for (int i = 0; i < 4; i++) begin
      step("starve_deny", 1'b1, 32'h200 + 32'(4*i), 4'hF, 32'h1000 + 32'(i),
           1'b1, 32'h40, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    chk("starve_state_force", 32'(dut.state_q), 32'h1);
    chk("starve_cnt_limit", 32'(dut.starve_cnt_q), 32'd4);
    step("starve_force", 1'b1, 32'h210, 4'hF, 32'h2000, 1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
    chk("starve_state_normal", 32'(dut.state_q), 32'h0);
    chk("starve_cnt_clear", 32'(dut.starve_cnt_q), 32'd0);
    step("starve_regain", 1'b1, 32'h210, 4'hF, 32'h2000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle("starve_idle");

    // Alternating reads, then m0 write against a pending m1 read.
    step("alt_m1", 1'b0, 32'h0,  4'h0, 32'h0, 1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
    step("alt_m0", 1'b1, 32'h80, 4'h0, 32'h0, 1'b0, 32'h0,  4'h0, 32'h0, 1'b1, 1'b0, 32'h3333_4444);
    idle("alt_idle");
    step("wr_vs_rd0", 1'b1, 32'h300, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h80, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    step("wr_vs_rd1", 1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 32'h80, 4'h0, 32'h0, 1'b0, 1'b1, 32'h3333_4444);
    idle("wr_vs_rd_idle");

    // Byte-enabled m1 write, no response; read back merges with old bytes.
    step("m1wr", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 4'b0011, 32'h0000_ABCD, 1'b0, 1'b1, 32'h0);
    idle("m1wr_idle");
    step("m1wr_rb", 1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h1234_ABCD);
    idle("m1wr_rb_idle");

    // Reset asserted after an m0 read grant, before the response edge.
    m0_req = 1'b1; m0_addr = 32'h100; m0_wen = 4'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_addr = 32'h0;   m1_wen = 4'h0; m1_wdata = 32'h0;
    @(negedge clk);
    chk("midrd_gnt", 32'(m0_gnt), 32'h1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrd_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
    chk("midrd_ram_en", 32'(ram_en), 32'h0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    reset = 1'b1;
    chk("midrd_state", 32'(dut.state_q), 32'h0);
    idle("midrd_idle0");
    idle("midrd_idle1");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port synchronous Data RAM between two requesters.
  - Requester 0 (m0) is the pipeline data port driven by the EXE stage.
  - Requester 1 (m1) is a secondary master: instruction-fetch refill or debug loader.
- Grants at most one access per cycle.
- Routes read data back to the owning requester one cycle later.
- m0 has priority. A starvation counter forces an m1 grant after a bounded wait.

Parameters:
- STARVE_LIMIT, 4: consecutive denied m1 cycles before m1 is forced. Legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  m0 access request; held stable until granted
- m0_addr  in  32  m0 byte address
- m0_wen  in  4  m0 byte write enables; 0000 = read
- m0_wdata  in  32  m0 write data
- m0_gnt  out  1  m0 access accepted this cycle
- m0_rvalid  out  1  m0 read data valid
- m0_rdata  out  32  m0 read data
- m1_req, m1_addr, m1_wen, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for requester 1
- ram_en  out  1  RAM enable
- ram_addr  out  32  RAM address
- ram_wen  out  4  RAM byte write enables
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid 1 cycle after a read enable

Behaviour:
- Transfer handshake:
  - A transfer occurs when req & gnt are both 1 in the same cycle.
  - gnt is combinational from req and registered state.
  - A requester not granted keeps req and its payload unchanged.
- RAM port:
  - ram_en = m0_gnt | m1_gnt.
  - ram_addr, ram_wen and ram_wdata mux from the granted master.
  - When nothing is granted these outputs are 0.
  - m0_gnt & m1_gnt is never 1.
- FSM states:
  - NORMAL:
    - m0_gnt = m0_req.
    - m1_gnt = m1_req & ~m0_req.
  - FORCE_M1:
    - m1_gnt = m1_req.
    - m0_gnt = m0_req & ~m1_req.
- starve_cnt (4 bits):
  - Increments in any cycle where m1_req=1 and m1_gnt=0.
  - Clears to 0 on m1_gnt, or when m1_req=0.
- Transitions:
  - NORMAL -> FORCE_M1 on the clock edge where starve_cnt==STARVE_LIMIT-1 and m1 is denied. starve_cnt then holds at STARVE_LIMIT.
  - FORCE_M1 -> NORMAL on m1_gnt, or if m1_req drops (starve_cnt cleared).
  - With STARVE_LIMIT=1, one denied cycle forces the next cycle to m1.
- Response tracking:
  - On a granted read (wen==0000), resp_valid<=1 and resp_id<=granting master. Otherwise resp_valid<=0.
  - mX_rvalid = resp_valid & (resp_id==X).
  - mX_rdata = ram_rdata when mX_rvalid, else 0.
  - Writes produce no response.
  - Back-to-back reads from alternating masters are legal. Each response lands exactly 1 cycle after its grant.
- Simultaneous events:
  - If both request in FORCE_M1, m1 wins.
  - A write and a read never share a cycle; one is deferred.
- Reset:
  - While reset=0, FSM=NORMAL, starve_cnt=0, resp_valid=0.
  - All outputs are 0: gnt, rvalid, rdata, ram_*.
  - Reset asserted mid-read discards the pending response. No rvalid appears after reset deasserts.
- Unsupported: no queuing. Latency is fixed at 1 cycle for reads; the RAM is always ready.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 with m0_req=m1_req=1.
  - Response: all outputs 0. After release, first cycle m0_gnt=1, m1_gnt=0.
- m0 read:
  - Stimulus: m0 read at addr 0x100; RAM returns 0xDEADBEEF.
  - Response: ram_en=1, ram_addr=0x100, ram_wen=0 in cycle N. m0_rvalid=1 with rdata 0xDEADBEEF in N+1. m1_rvalid stays 0.
- Starvation:
  - Stimulus: m0_req held high every cycle, m1_req high from cycle 0, STARVE_LIMIT=4.
  - Response: m1 denied cycles 0-3. m1_gnt=1, m0_gnt=0 in cycle 4. m0 regains grant in cycle 5 and starve_cnt=0.
- Alternating reads:
  - Stimulus: m1 read 0x40 in cycle N (m0 idle), m0 read 0x80 in N+1.
  - Response: m1_rvalid in N+1, m0_rvalid in N+2. Each carries its own ram_rdata; no cross-routing.
- Write with byte enables:
  - Stimulus: m1 write wen=0011, wdata=0x0000ABCD, addr 0x8 in cycle N.
  - Response: ram_wen=0011, ram_wdata=0x0000ABCD in cycle N. No rvalid in N+1.
- Reset mid-read:
  - Stimulus: grant an m0 read, then assert reset before the next edge.
  - Response: m0_rvalid never asserts, and the FSM returns to NORMAL.
